// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM definitions used by the cyclic-prefix insert/remove blocks.
package ofdm_pkg;

   typedef enum logic {S_CP, S_DATA} state_t;

   // Counter width needed to index the longer of two segments (never below 1 bit).
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/ofdm_remove_cp.sv
// ofdm_remove_cp: drops the cyclic prefix of each OFDM symbol and forwards the
// useful samples with one cycle of latency.
module ofdm_remove_cp
   import ofdm_pkg::*;
#(
   parameter int DATA_SIZE    = 16,
   parameter int SYMBOLS_SIZE = 256,
   parameter int CP_LENGHT    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [DATA_SIZE-1:0] in_data_i,
   input  logic [DATA_SIZE-1:0] in_data_q,
   input  logic                 i_frame_sync,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data_i,
   output logic [DATA_SIZE-1:0] out_data_q
);

   localparam int CW = cnt_width(CP_LENGHT, SYMBOLS_SIZE);
   localparam logic [CW-1:0] CP_LAST  = CW'(CP_LENGHT - 1);
   localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOLS_SIZE - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          fwd;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= S_CP;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // A sync sample is CP index 0; with a one-sample prefix it already ends the CP.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fwd     = 1'b0;
      if (i_frame_sync) begin
         state_n = (i_valid && CP_LAST == '0) ? S_DATA : S_CP;
         cnt_n   = (i_valid && CP_LAST != '0) ? ONE : '0;
      end else if (i_valid) begin
         if (state == S_CP) begin
            state_n = (cnt == CP_LAST) ? S_DATA : S_CP;
            cnt_n   = (cnt == CP_LAST) ? '0 : cnt + ONE;
         end else begin
            fwd     = 1'b1;
            state_n = (cnt == SYM_LAST) ? S_CP : S_DATA;
            cnt_n   = (cnt == SYM_LAST) ? '0 : cnt + ONE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         out_valid  <= 1'b0;
         out_data_i <= '0;
         out_data_q <= '0;
      end else begin
         out_valid <= fwd;
         if (fwd) begin
            out_data_i <= in_data_i;
            out_data_q <= in_data_q;
         end
      end
   end

endmodule

// File: tb/tb_ofdm_remove_cp.sv
// tb_ofdm_remove_cp: randomized self-checking bench for ofdm_remove_cp against a
// frame-position reference model plus a symbol scoreboard.
module tb_ofdm_remove_cp;

   localparam int DW  = 16;
   localparam int SYM = 256;
   localparam int CP  = 8;
   localparam int FL  = CP + SYM;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic [DW-1:0] in_data_i = '0;
   logic [DW-1:0] in_data_q = '0;
   logic          i_frame_sync = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data_i;
   logic [DW-1:0] out_data_q;

   int errors = 0;
   int checks = 0;

   int            pos = 0;
   logic          exp_v = 1'b0;
   logic [DW-1:0] exp_i = '0;
   logic [DW-1:0] exp_q = '0;
   logic          sb_on = 1'b0;
   logic [2*DW-1:0] sb[$];

   ofdm_remove_cp #(.DATA_SIZE(DW), .SYMBOLS_SIZE(SYM), .CP_LENGHT(CP)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_valid(i_valid),
      .in_data_i(in_data_i),
      .in_data_q(in_data_q),
      .i_frame_sync(i_frame_sync),
      .out_valid(out_valid),
      .out_data_i(out_data_i),
      .out_data_q(out_data_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Check outputs of the previous edge, then present the next input and
   // predict what the following edge must produce.
   task automatic step(input logic v, input logic [DW-1:0] di, input logic [DW-1:0] dq,
                       input logic fs);
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("out_data", 64'({out_data_i, out_data_q}), 64'({exp_i, exp_q}));
      if (sb_on && out_valid) begin
         if (sb.size() == 0) chk("sym_empty", 64'(1), 64'(0));
         else chk("sym_data", 64'({out_data_i, out_data_q}), 64'(sb.pop_front()));
      end
      i_valid      = v;
      in_data_i    = di;
      in_data_q    = dq;
      i_frame_sync = fs;
      exp_v = 1'b0;
      if (fs) begin
         pos = v ? 1 : 0;
      end else if (v) begin
         if (pos >= CP) begin
            exp_v = 1'b1;
            exp_i = di;
            exp_q = dq;
         end
         pos = (pos + 1) % FL;
      end
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'({out_data_i, out_data_q}), 64'(0));
      pos   = 0;
      exp_v = 1'b0;
      exp_i = '0;
      exp_q = '0;
      i_valid      = 1'b0;
      i_frame_sync = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] ri, rq;
      logic [2*DW-1:0] symq[$];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_valid", 64'(out_valid), 64'(0));
      chk("reset_data", 64'({out_data_i, out_data_q}), 64'(0));

      // Continuous stream, value = index, a full frame plus one extra CP.
      for (int k = 0; k < FL + CP; k++) step(1'b1, DW'(k), DW'(k ^ 16'h5a5a), 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0);

      // Alternating valid.
      pulse_reset();
      for (int k = 0; k < FL + CP; k++) begin
         step(1'b1, DW'(k), DW'(~k), 1'b0);
         step(1'b0, 16'hdead, 16'hbeef, 1'b0);
      end

      // Frame sync at useful index 100.
      pulse_reset();
      for (int k = 0; k < CP + 100; k++) step(1'b1, DW'(k), DW'(k + 7), 1'b0);
      step(1'b1, 16'h1111, 16'h2222, 1'b1);
      for (int k = 0; k < FL + 4; k++) step(1'b1, DW'(1000 + k), DW'(k), 1'b0);

      // Frame sync without a valid sample, then idle gaps.
      step(1'b0, '0, '0, 1'b1);
      for (int k = 0; k < 40; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);

      // Reset at useful index 50.
      pulse_reset();
      for (int k = 0; k < CP + 50; k++) step(1'b1, DW'(k), DW'(k), 1'b0);
      pulse_reset();
      for (int k = 0; k < CP + 20; k++) step(1'b1, DW'(500 + k), DW'(k), 1'b0);

      // Add-CP style source: random symbols, CP = last CP samples, random gaps.
      pulse_reset();
      sb_on = 1'b1;
      for (int s = 0; s < 5; s++) begin
         symq.delete();
         for (int n = 0; n < SYM; n++) begin
            ri = DW'($urandom);
            rq = DW'($urandom);
            symq.push_back({ri, rq});
            sb.push_back({ri, rq});
         end
         for (int n = 0; n < FL; n++) begin
            ri = symq[(n < CP) ? SYM - CP + n : n - CP][2*DW-1:DW];
            rq = symq[(n < CP) ? SYM - CP + n : n - CP][DW-1:0];
            if ($urandom_range(3) == 0) step(1'b0, DW'($urandom), DW'($urandom), 1'b0);
            step(1'b1, ri, rq, 1'b0);
         end
      end
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0);
      chk("sym_left", 64'(sb.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
